// File: rtl/aes_inv_key_expand.sv
// AES-128 reverse key schedule: runs the schedule forward to the last round key,
// then walks back one round key per consumer handshake down to the cipher key.

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  // Row-major FIPS-197 S-box; entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y_o = SBOX[{~a_i, 3'b000} +: 8];
endmodule

module aes_inv_key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [127:0] key,
  input  logic         rk_next,
  output logic         busy,
  output logic         kv,
  output logic [3:0]   round_idx,
  output logic         done,
  output logic [31:0]  w0,
  output logic [31:0]  w1,
  output logic [31:0]  w2,
  output logic [31:0]  w3
);
  // Handshake: a presented key (kv=1) is consumed on every rising edge where
  // kv && rk_next; the next key (or done) follows on the next cycle.
  typedef enum logic [1:0] {IDLE, FWD, OUT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] w0_q, w1_q, w2_q, w3_q;
  logic [31:0] w0_d, w1_d, w2_d, w3_d;
  logic        done_q, done_d;

  logic [31:0] sbox_src, rot, sub, t;
  logic [3:0]  r_cur;
  logic [31:0] f0, f1, f2, f3;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Backwards, the word needed for SubWord is the previous round's w3 = w3^w2.
  assign sbox_src = (state_q == OUT) ? (w3_q ^ w2_q) : w3_q;
  assign rot      = {sbox_src[23:0], sbox_src[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.a_i(rot[8*i +: 8]), .y_o(sub[8*i +: 8]));
  end

  assign r_cur = (state_q == FWD) ? (cnt_q + 4'd1) : cnt_q;
  assign t     = sub ^ {rcon(r_cur), 24'h000000};

  assign f0 = w0_q ^ t;
  assign f1 = w1_q ^ f0;
  assign f2 = w2_q ^ f1;
  assign f3 = w3_q ^ f2;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    w3_d    = w3_q;
    done_d  = 1'b0;
    if (ld) begin
      state_d = FWD;
      cnt_d   = 4'd0;
      {w0_d, w1_d, w2_d, w3_d} = key;
    end else begin
      case (state_q)
        FWD: begin
          {w0_d, w1_d, w2_d, w3_d} = {f0, f1, f2, f3};
          cnt_d = r_cur;
          if (r_cur == 4'(NR)) state_d = OUT;
        end
        OUT: begin
          if (rk_next) begin
            if (cnt_q != 4'd0) begin
              w3_d  = w3_q ^ w2_q;
              w2_d  = w2_q ^ w1_q;
              w1_d  = w1_q ^ w0_q;
              w0_d  = w0_q ^ t;
              cnt_d = cnt_q - 4'd1;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      w0_q    <= 32'h0;
      w1_q    <= 32'h0;
      w2_q    <= 32'h0;
      w3_q    <= 32'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign kv        = (state_q == OUT);
  assign round_idx = cnt_q;
  assign done      = done_q;
  assign w0        = w0_q;
  assign w1        = w1_q;
  assign w2        = w2_q;
  assign w3        = w3_q;
endmodule

// File: tb/tb_aes_inv_key_expand.sv
// Directed bench for the AES-128 reverse key schedule using FIPS-197 round keys.

module tb_aes_inv_key_expand;
  logic         clk = 1'b0;
  logic         rst, ld, rk_next;
  logic [127:0] key;
  logic         busy, kv, done;
  logic [3:0]   round_idx;
  logic [31:0]  w0, w1, w2, w3;

  int passed = 0;
  int total  = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] w;
  } vec_t;

  vec_t fips_tab[11];

  aes_inv_key_expand dut (
    .clk(clk), .rst(rst), .ld(ld), .key(key), .rk_next(rk_next),
    .busy(busy), .kv(kv), .round_idx(round_idx), .done(done),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] wbus();
    return {w0, w1, w2, w3};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [127:0] k);
    ld  = 1'b1;
    key = k;
    tick();
    ld  = 1'b0;
  endtask

  // Call right after load(): checks the exact 11-edge latency and the round-NR key.
  task automatic expect_r10(input string tag, input logic [127:0] exp_w);
    logic bad;
    chk({tag, "_busy_after_ld"}, 128'(busy), 128'd1);
    bad = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (kv || done || !busy) bad = 1'b1;
      tick();
    end
    chk({tag, "_fwd_no_kv_no_done"}, 128'(bad | kv | done), 128'd0);
    tick();
    chk({tag, "_kv_at_edge11"}, 128'(kv), 128'd1);
    chk({tag, "_round_idx10"}, 128'(round_idx), 128'd10);
    chk({tag, "_r10_key"}, wbus(), exp_w);
  endtask

  initial begin
    fips_tab[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    fips_tab[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    fips_tab[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    fips_tab[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    fips_tab[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    fips_tab[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    fips_tab[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    fips_tab[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    fips_tab[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    fips_tab[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    fips_tab[10] = '{4'd0,  FIPS_KEY};

    rst = 1'b1; ld = 1'b0; rk_next = 1'b0; key = '0;
    tick(); tick();
    chk("reset_ctrl", 128'({busy, kv, done, round_idx}), 128'd0);
    chk("reset_words", wbus(), 128'd0);
    rst = 1'b0;
    tick();

    // Scenarios 1-3: forward run, then walk back through every round key.
    load(FIPS_KEY);
    expect_r10("s1", fips_tab[0].w);
    rk_next = 1'b1;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("s3_kv_r%0d", fips_tab[i].rnd), 128'(kv), 128'd1);
      chk($sformatf("s3_idx_r%0d", fips_tab[i].rnd), 128'(round_idx), 128'(fips_tab[i].rnd));
      chk($sformatf("s3_key_r%0d", fips_tab[i].rnd), wbus(), fips_tab[i].w);
      tick();
    end
    chk("s3_done_pulse", 128'(done), 128'd1);
    chk("s3_busy_low", 128'(busy), 128'd0);
    chk("s3_kv_low", 128'(kv), 128'd0);
    chk("s3_key_kept", wbus(), FIPS_KEY);
    tick();
    chk("s3_done_one_cycle", 128'(done), 128'd0);
    rk_next = 1'b0;
    tick();

    // Scenario 4: rk_next ignored during FWD, then a 20-cycle hold in OUT.
    ld = 1'b1; key = FIPS_KEY; rk_next = 1'b1;
    tick();
    ld = 1'b0;
    repeat (9) tick();
    rk_next = 1'b0;
    tick();
    chk("s4_idx_after_fwd_rk", 128'(round_idx), 128'd10);
    chk("s4_key_after_fwd_rk", wbus(), fips_tab[0].w);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("s4_hold_key_c%0d", i), wbus(), fips_tab[0].w);
      chk($sformatf("s4_hold_idx_c%0d", i), 128'({kv, round_idx}), 128'({1'b1, 4'd10}));
    end

    // Scenario 5: abort at round 5 with ld (rk_next also high; ld wins).
    rk_next = 1'b1;
    repeat (5) tick();
    rk_next = 1'b0;
    chk("s5_idx_r5", 128'(round_idx), 128'd5);
    chk("s5_key_r5", wbus(), fips_tab[5].w);
    ld = 1'b1; key = 128'd0; rk_next = 1'b1;
    tick();
    ld = 1'b0; rk_next = 1'b0;
    chk("s5_no_done_on_abort", 128'(done), 128'd0);
    chk("s5_loaded_zero", wbus(), 128'd0);
    expect_r10("s5", ZERO_R10);
    rk_next = 1'b1;
    repeat (9) tick();
    chk("s5_idx_r1", 128'(round_idx), 128'd1);
    chk("s5_key_r1", wbus(), ZERO_R1);
    tick();
    chk("s5_key_r0", wbus(), 128'd0);
    tick();
    chk("s5_done", 128'(done), 128'd1);
    rk_next = 1'b0;
    tick();

    // Scenario 6: reset in the middle of FWD, then an identical rerun.
    load(FIPS_KEY);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("s6_rst_ctrl", 128'({busy, kv, done, round_idx}), 128'd0);
    chk("s6_rst_words", wbus(), 128'd0);
    rst = 1'b0;
    tick();
    load(FIPS_KEY);
    expect_r10("s6", fips_tab[0].w);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
